// File: rtl/seven_segments_scanner.sv
// ============================================================================
// Module      : seven_segments_scanner
// Description : Time-multiplexed scan controller for a common-cathode
//               multi-digit seven-segment display, with per-slot blanking,
//               frame-synchronous double buffering and leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_segments_scanner #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  lz_blank,
    output logic [3:0]            binary,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_tick,
    output logic                  pending
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW = 4 * DIGITS;

    localparam logic [CW-1:0] C_CNT_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] C_BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] C_IDX_LAST   = IW'(DIGITS - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam state_t C_ST_RESET = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

    logic [CW-1:0] r_cnt;
    logic [IW-1:0] r_idx;
    logic [VW-1:0] r_shadow;
    logic [VW-1:0] r_active;
    state_t        r_state;
    state_t        w_state_next;

    logic          w_slot_end;
    logic          w_frame_end;
    logic          w_commit;
    logic [IW-1:0] w_idx_next;
    logic [VW-1:0] w_active_next;
    logic [3:0]    w_nib_next [DIGITS];
    logic          w_upper_nz [DIGITS];
    logic          w_suppressed;

    assign w_slot_end    = (r_cnt == C_CNT_LAST);
    assign w_frame_end   = w_slot_end && (r_idx == C_IDX_LAST);
    assign w_commit      = w_frame_end && pending;
    assign w_idx_next    = (r_idx == C_IDX_LAST) ? '0 : r_idx + IW'(1);
    // The digit-0 nibble of a freshly committed value must appear on the
    // same edge as the commit, so the binary mux looks at post-commit data.
    assign w_active_next = w_commit ? r_shadow : r_active;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_nib_next[gi] = w_active_next[4*gi +: 4];
            assign w_upper_nz[gi] = |r_active[VW-1:4*gi];
        end
    endgenerate

    assign w_suppressed = lz_blank && (r_idx != '0) && !w_upper_nz[r_idx];

    // Datapath and scan counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shadow <= '0;
            r_active <= '0;
            binary   <= 4'h0;
            pending  <= 1'b0;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + CW'(1);
            if (w_slot_end) begin
                r_idx  <= w_idx_next;
                binary <= w_nib_next[w_idx_next];
            end
            if (w_commit) begin
                r_active <= r_shadow;
            end
            if (load) begin
                r_shadow <= value;
                pending  <= 1'b1;
            end else if (w_commit) begin
                pending  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_ST_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        digit_en     = '0;
        case (r_state)
            ST_BLANK: begin
                if ((BLANK_CYCLES > 0) && (r_cnt == C_BLANK_LAST)) begin
                    w_state_next = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (w_slot_end) begin
                    w_state_next = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;
                end
                // Gate with rst_n so enables drop immediately during reset
                // even when there is no blanking state to fall back to.
                if (rst_n && !w_suppressed) begin
                    digit_en = DIGITS'(1) << r_idx;
                end
            end
            default: w_state_next = C_ST_RESET;
        endcase
    end

    assign frame_tick = rst_n && w_frame_end;

endmodule

`default_nettype wire

// File: tb/tb_seven_segments_scanner.sv
// ============================================================================
// Module      : tb_seven_segments_scanner
// Description : Scoreboard bench for seven_segments_scanner (DIGITS=4,
//               PRESCALE=8) with one BLANK_CYCLES=2 and one =0 instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_segments_scanner;

    localparam int D = 4;
    localparam int P = 8;
    localparam int B = 2;
    localparam int F = D * P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic        lz_blank = 1'b0;
    logic [3:0]  binary;
    logic [3:0]  digit_en;
    logic        frame_tick;
    logic        pending;
    logic [3:0]  binary0;
    logic [3:0]  digit_en0;
    logic        frame_tick0;
    logic        pending0;

    seven_segments_scanner #(.DIGITS(D), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .lz_blank(lz_blank),
        .binary(binary), .digit_en(digit_en), .frame_tick(frame_tick), .pending(pending)
    );

    seven_segments_scanner #(.DIGITS(D), .PRESCALE(P), .BLANK_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .lz_blank(1'b0),
        .binary(binary0), .digit_en(digit_en0), .frame_tick(frame_tick0), .pending(pending0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] bin;
        logic [3:0] en;
        logic       tick;
        logic       pend;
        logic [3:0] en0;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: displayed value, buffered value and cycle count since release
    int          t = 0;
    bit          in_rst = 1'b1;
    logic [15:0] m_active = 16'h0;
    logic [15:0] m_shadow = 16'h0;
    bit          m_pend = 1'b0;

    function automatic exp_t predict(bit lz);
        exp_t e;
        int   slot;
        int   pos;
        bit   supp;
        e = '{bin: 4'h0, en: 4'h0, tick: 1'b0, pend: 1'b0, en0: 4'h0};
        if (!in_rst) begin
            slot   = (t / P) % D;
            pos    = t % P;
            e.bin  = 4'((m_active >> (4 * slot)) & 16'hF);
            supp   = lz && (slot > 0) && ((m_active >> (4 * slot)) == 16'h0);
            e.en   = (pos < B || supp) ? 4'h0 : 4'(1 << slot);
            e.en0  = 4'(1 << slot);
            e.tick = ((t % F) == F - 1);
            e.pend = m_pend;
        end
        return e;
    endfunction

    task automatic step(input bit rst, input bit ld, input logic [15:0] v, input bit lz);
        @(posedge clk);
        #1;
        rst_n    = !rst;
        load     = ld && !rst;
        value    = v;
        lz_blank = lz;
        if (rst) begin
            in_rst   = 1'b1;
            m_active = 16'h0;
            m_shadow = 16'h0;
            m_pend   = 1'b0;
            t        = 0;
        end else if (in_rst) begin
            in_rst = 1'b0;
            t      = 0;
        end
        q.push_back(predict(lz));
        if (!rst) begin
            if (((t % F) == F - 1) && m_pend) begin
                m_active = m_shadow;
                m_pend   = 1'b0;
            end
            if (ld) begin
                m_shadow = v;
                m_pend   = 1'b1;
            end
            t++;
        end
    endtask

    task automatic idle(input int n, input bit lz);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, lz);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("binary",     binary,            e.bin);
            check("digit_en",   digit_en,          e.en);
            check("frame_tick", {3'b0, frame_tick}, {3'b0, e.tick});
            check("pending",    {3'b0, pending},    {3'b0, e.pend});
            check("binary_b0",  binary0,           e.bin);
            check("digit_en_b0", digit_en0,        e.en0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit lz;
        // Reset, then idle scan with a load of 0x1234 at cycle 5
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 64; i++) step(1'b0, i == 5, 16'h1234, 1'b0);
        // Two loads in one frame: only the last is ever shown
        for (int i = 0; i < 96; i++)
            step(1'b0, (i == 3) || (i == 20), (i == 3) ? 16'h1111 : 16'h2222, 1'b0);
        // Leading-zero suppression
        step(1'b0, 1'b1, 16'h0040, 1'b1);
        idle(95, 1'b1);
        step(1'b0, 1'b1, 16'h0000, 1'b1);
        idle(63, 1'b1);
        // Load coincident with commit
        step(1'b0, 1'b1, 16'h0005, 1'b0);
        idle(30, 1'b0);
        step(1'b0, 1'b1, 16'h0009, 1'b0);
        idle(95, 1'b0);
        // Reset mid-frame with a pending value
        while ((t % F) != 0) idle(1, 1'b0);
        idle(3, 1'b0);
        step(1'b0, 1'b1, 16'h0777, 1'b0);
        while ((t % F) != 20) idle(1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
        idle(70, 1'b0);
        // Randomized loads, values (including non-BCD), lz_blank and resets
        lz = 1'b0;
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 49) == 0) lz = !lz;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0,
                 16'($urandom), lz);
        end
        idle(2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seven_segments_scanner.md
# seven_segments_scanner

Time-multiplexed scan controller for a multi-digit common-cathode seven-segment display. It drives one shared `seven_segments` decoder by presenting one BCD nibble at a time on `binary`, and it selects the matching digit through one-hot enables. Between digits it inserts a blanking interval to suppress ghosting. New display values are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- `DIGITS`, default 4: number of digits scanned; legal range 1..8.
- `PRESCALE`, default 1000: clock cycles per digit slot; must be > `BLANK_CYCLES`.
- `BLANK_CYCLES`, default 2: cycles at the start of each slot with all enables low; may be 0.

- `clk`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load`  in  1  one-cycle strobe; captures `value` into the shadow register.
- `value`  in  4*DIGITS  BCD digits; nibble i (bits 4i+3:4i) is digit i, and digit 0 is least significant.
- `lz_blank`  in  1  leading-zero suppression enable.
- `binary`  out  4  nibble to the `seven_segments` decoder.
- `digit_en`  out  DIGITS  one-hot, active-high digit select.
- `frame_tick`  out  1  high during the last cycle of each frame.
- `pending`  out  1  shadow holds a value not yet committed.

## Operation
- Internal state:
  - `shadow` and `active` registers, each 4*DIGITS bits.
  - `pending` flag.
  - Slot counter `cnt` (0..PRESCALE-1).
  - Digit index `idx` (0..DIGITS-1).
- `cnt` increments every cycle.
  - At PRESCALE-1 it wraps to 0 and `idx` advances.
  - `idx` wraps from DIGITS-1 to 0.
- The scan FSM has two states per slot:
  - BLANK while `cnt` < BLANK_CYCLES.
  - SHOW otherwise.
  - BLANK→SHOW when `cnt` == BLANK_CYCLES-1 (skipped if BLANK_CYCLES = 0).
  - SHOW→BLANK, or SHOW→SHOW when BLANK_CYCLES = 0, at slot wrap.
- Outputs by state:
  - `binary` = `active` nibble `idx`, registered and updated on the same edge that changes `idx`.
  - `digit_en` = 0 in BLANK.
  - `digit_en` = (1 << `idx`) in SHOW, unless digit `idx` is suppressed.
- Suppression applies only when `lz_blank` = 1. Digit i > 0 is suppressed when all `active` nibbles i..DIGITS-1 are zero.
  - Digit 0 is never suppressed.
  - Suppression is evaluated from `active`, never from `shadow`.
- `load` = 1: `shadow` <= `value`, `pending` <= 1.
- `frame_tick` = (`idx` == DIGITS-1 && `cnt` == PRESCALE-1).
- Commit happens on the edge ending a `frame_tick` cycle when `pending` = 1:
  - `active` <= `shadow`.
  - `pending` <= 0.
- `load` coincident with commit:
  - `shadow` pre-edge contents are committed.
  - `shadow` then takes the new `value`.
  - `pending` stays 1, so the new value shows one frame later.
- Multiple loads within one frame: the last one wins; earlier values are never displayed.
- Non-BCD nibbles (A–F) pass through unchanged; the decoder shows its error glyph for them.
- Reset values while `rst_n` = 0, applied immediately and independent of `clk`:
  - `binary` = 0, `digit_en` = 0, `frame_tick` = 0, `pending` = 0.
  - `shadow` = 0, `active` = 0, `cnt` = 0, `idx` = 0.
  - FSM in BLANK (or SHOW if BLANK_CYCLES = 0).
- Reset mid-frame drops any uncommitted load. Scan restarts at digit 0, cycle 0, after release.

## Timing
- The first edge after `rst_n` rises is cycle 0 of slot 0.
- Frame length is DIGITS*PRESCALE cycles.
- Within a slot:
  - `digit_en` is low for exactly BLANK_CYCLES cycles.
  - It is then high for PRESCALE-BLANK_CYCLES cycles.
- `binary` is stable for the whole slot, including the blanking cycles.
- `load` to `pending` high: 1 cycle.
- Commit to new `binary` at digit 0: same edge. `binary` reflects new `active` in the first cycle of the next frame.
- Worst-case latency from `load` to display is one frame plus BLANK_CYCLES.
- `frame_tick` is exactly one cycle wide, once per frame.

## Test plan
DIGITS=4, PRESCALE=8, BLANK_CYCLES=2 unless noted.
- Reset release, no load:
  - `digit_en` = 0 in cycles 0–1, 0001 in cycles 2–7, 0010 in cycles 10–15, and so on.
  - `binary` = 0 throughout.
  - `frame_tick` high only in cycles 31, 63, ….
- `load` value=0x1234 at cycle 5:
  - `pending` = 1 from cycle 6 until the edge ending cycle 31.
  - `binary` = 0 through cycle 31.
  - `binary` = 4 in cycles 32–39, 3 in cycles 40–47, 2 in 48–55, 1 in 56–63.
- Loads 0x1111 at cycle 3 and 0x2222 at cycle 20: frame 2 shows `binary` = 2 for every digit; 1 never appears.
- `lz_blank`=1, commit 0x0040:
  - Digits 2 and 3 never assert `digit_en`.
  - Digit 0 shows `binary` 0 and digit 1 shows 4.
  - Value 0x0000 enables only digit 0.
- `load` 0x0009 in cycle 31 while `pending` holds 0x0005:
  - Frame 2 shows 5.
  - `pending` stays 1.
  - Frame 3 shows 9.
- `rst_n` low at cycle 20 with `pending` = 1:
  - All outputs go to 0 in the same cycle.
  - After release the scan restarts at digit 0, and the loaded value is never displayed.
- BLANK_CYCLES=0: `digit_en` is never all-zero after reset release, and enables switch on slot boundaries only.
